// File: rtl/class_argmax.sv
// class_argmax: drains {last, score} words from a non-show-ahead FIFO and
// reports, per image of NUM_CLASS scores, the index and value of the largest
// signed score (ties keep the earliest index) plus a framing-error flag.
// Optional build macro ARGMAX_TOP2_EN adds the runner-up (res_class2/res_score2).
module class_argmax #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CLASS  = 1000,
    parameter int IDX_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_last,
    input  logic                  fifo_empty,
    output logic                  fifo_rdreq,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [IDX_WIDTH-1:0]  res_class,
    output logic [DATA_WIDTH-1:0] res_score,
    output logic                  res_err
`ifdef ARGMAX_TOP2_EN
    ,
    output logic [IDX_WIDTH-1:0]  res_class2,
    output logic [DATA_WIDTH-1:0] res_score2
`endif
);

    // The issue counter must reach NUM_CLASS itself, which may need one bit
    // more than a class index does.
    localparam int                   CNT_W     = IDX_WIDTH + 1;
    localparam logic [CNT_W-1:0]     ISSUE_MAX = CNT_W'(NUM_CLASS);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_CLASS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       issued_q, issued_d;
    logic [IDX_WIDTH-1:0]   cnt_q, cnt_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic signed [DATA_WIDTH-1:0] max_q, max_d;
    logic                   err_q, err_d;
    // A pop issued last cycle means fifo_data holds a word to sample now.
    logic                   pend_q, pend_d;
    logic                   rdreq;
    logic                   take_new;
    logic signed [DATA_WIDTH-1:0] score;

`ifdef ARGMAX_TOP2_EN
    logic [IDX_WIDTH-1:0]   idx2_q, idx2_d;
    logic signed [DATA_WIDTH-1:0] sec_q, sec_d;
`endif

    assign score = $signed(fifo_data);

    // Next-state, pop request and running max/err update.
    always_comb begin
        state_d  = state_q;
        issued_d = issued_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        max_d    = max_q;
        err_d    = err_q;
        rdreq    = 1'b0;
        take_new = 1'b0;
`ifdef ARGMAX_TOP2_EN
        idx2_d   = idx2_q;
        sec_d    = sec_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                issued_d = '0;
                idx_d    = '0;
                max_d    = '0;
                err_d    = 1'b0;
`ifdef ARGMAX_TOP2_EN
                idx2_d   = '0;
                sec_d    = '0;
`endif
                state_d  = SCAN;
            end
            SCAN: begin
                // Requests stop once the whole image has been issued so the
                // next image's words stay queued in the FIFO.
                rdreq = !reset && !fifo_empty && (issued_q < ISSUE_MAX);
                if (rdreq) begin
                    issued_d = issued_q + 1'b1;
                end
                if (pend_q) begin
                    take_new = (cnt_q == '0) || (score > max_q);
                    if (take_new) begin
                        max_d = score;
                        idx_d = cnt_q;
                    end
`ifdef ARGMAX_TOP2_EN
                    // A new leader demotes the old one; otherwise the word
                    // may still beat the runner-up. The second word seen is
                    // always a valid runner-up when it does not lead.
                    if (take_new) begin
                        if (cnt_q != '0) begin
                            sec_d  = max_q;
                            idx2_d = idx_q;
                        end
                    end else if ((cnt_q == IDX_WIDTH'(1)) || (score > sec_q)) begin
                        sec_d  = score;
                        idx2_d = cnt_q;
                    end
`endif
                    if ((fifo_last && (cnt_q != LAST_IDX)) ||
                        (!fifo_last && (cnt_q == LAST_IDX))) begin
                        err_d = 1'b1;
                    end
                    cnt_d = cnt_q + 1'b1;
                    // The count, not the last flag, closes the image.
                    if (cnt_q == LAST_IDX) begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pend_d = rdreq;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            issued_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            max_q    <= '0;
            err_q    <= 1'b0;
            pend_q   <= 1'b0;
`ifdef ARGMAX_TOP2_EN
            idx2_q   <= '0;
            sec_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            max_q    <= max_d;
            err_q    <= err_d;
            pend_q   <= pend_d;
`ifdef ARGMAX_TOP2_EN
            idx2_q   <= idx2_d;
            sec_q    <= sec_d;
`endif
        end
    end

    assign fifo_rdreq = rdreq;
    assign res_valid  = (state_q == EMIT);
    assign res_class  = idx_q;
    assign res_score  = max_q;
    assign res_err    = err_q;
`ifdef ARGMAX_TOP2_EN
    assign res_class2 = idx2_q;
    assign res_score2 = sec_q;
`endif

endmodule

// File: tb/tb_class_argmax.sv
// Directed bench for class_argmax with NUM_CLASS=4: a queue-based FIFO model,
// a per-image argmax scoreboard, and literal expectations per scenario.
module tb_class_argmax;
    localparam int DW = 32;
    localparam int NC = 4;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] fifo_data;
    logic          fifo_last;
    logic          fifo_empty;
    logic          fifo_rdreq;
    logic          res_valid;
    logic          res_ready;
    logic [IW-1:0] res_class;
    logic [DW-1:0] res_score;
    logic          res_err;
`ifdef ARGMAX_TOP2_EN
    logic [IW-1:0] res_class2;
    logic [DW-1:0] res_score2;
`endif

    class_argmax #(.DATA_WIDTH(DW), .NUM_CLASS(NC), .IDX_WIDTH(IW)) dut (
        .clk(clk), .reset(reset),
        .fifo_data(fifo_data), .fifo_last(fifo_last), .fifo_empty(fifo_empty),
        .fifo_rdreq(fifo_rdreq),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_class(res_class), .res_score(res_score), .res_err(res_err)
`ifdef ARGMAX_TOP2_EN
        , .res_class2(res_class2), .res_score2(res_score2)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int  c;
        int  s;
        bit  e;
        int  c2;
        int  s2;
    } res_t;

    res_t          expq[$];
    logic [DW:0]   fq[$];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            npop = 0;
    int            last_pop_cyc = -100;
    int            gap = 0;
    bit            gap_mode = 0;
    bit            do_pop;
    bit            prev_valid = 0;
    logic [DW:0]   w;
    res_t          head;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: argmax with first-index tie break, err when the last flag is
    // anywhere other than the final word, runner-up = best of the rest.
    task automatic push_image(input int s[NC], input bit l[NC]);
        res_t r;
        bit   found;
        r.c = 0;
        r.s = s[0];
        for (int i = 1; i < NC; i++) begin
            if (s[i] > r.s) begin
                r.s = s[i];
                r.c = i;
            end
        end
        r.e = 0;
        for (int i = 0; i < NC; i++) begin
            if (l[i] != (i == NC - 1)) r.e = 1;
        end
        found = 0;
        r.c2 = 0;
        r.s2 = 0;
        for (int i = 0; i < NC; i++) begin
            if (i != r.c && (!found || s[i] > r.s2)) begin
                r.s2 = s[i];
                r.c2 = i;
                found = 1;
            end
        end
        expq.push_back(r);
        for (int i = 0; i < NC; i++) fq.push_back({l[i], s[i]});
    endtask

    // FIFO model: non-show-ahead, optional 3-cycle empty gap after each pop.
    initial begin
        fifo_data  = '0;
        fifo_last  = 1'b0;
        fifo_empty = 1'b1;
        forever begin
            @(negedge clk);
            do_pop = 0;
            if (reset) begin
                npop = 0;
            end else if (fifo_rdreq) begin
                chk("rdreq_while_empty", longint'(fifo_empty), 0);
                chk("rdreq_during_emit", longint'(res_valid), 0);
                do_pop = 1;
                npop++;
                if (npop % NC == 0) last_pop_cyc = cyc;
            end
            @(posedge clk);
            #1;
            if (do_pop && fq.size() > 0) begin
                w = fq.pop_front();
                fifo_last = w[DW];
                fifo_data = w[DW-1:0];
                if (gap_mode) gap = 3;
            end else if (gap > 0) begin
                gap--;
            end
            fifo_empty = (fq.size() == 0) || (gap > 0);
        end
    end

    // Scoreboard compare on every cycle a result is presented.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (res_valid && !prev_valid) chk("latency", longint'(cyc - last_pop_cyc), 2);
                if (res_valid) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        head = expq[0];
                        chk("sb_class", longint'(res_class), longint'(head.c));
                        chk("sb_score", longint'($signed(res_score)), longint'(head.s));
                        chk("sb_err", longint'(res_err), longint'(head.e));
`ifdef ARGMAX_TOP2_EN
                        chk("sb_class2", longint'(res_class2), longint'(head.c2));
                        chk("sb_score2", longint'($signed(res_score2)), longint'(head.s2));
`endif
                        if (res_ready) void'(expq.pop_front());
                    end
                end
            end
            prev_valid = res_valid && !reset;
        end
    end

    // Wait (bounded) for a result, check literal values, then step past the edge.
    task automatic wait_res(input string name, input int c, input int s, input bit e,
                            input int c2, input int s2);
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1;
        end
        if (!seen) begin
            chk({name, "_timeout"}, 0, 1);
        end else begin
            $display("result %s: class=%0d score=%0d err=%0d", name, res_class,
                     $signed(res_score), res_err);
            chk({name, "_class"}, longint'(res_class), c);
            chk({name, "_score"}, longint'($signed(res_score)), s);
            chk({name, "_err"}, longint'(res_err), longint'(e));
`ifdef ARGMAX_TOP2_EN
            if (c2 >= 0) begin
                chk({name, "_class2"}, longint'(res_class2), c2);
                chk({name, "_score2"}, longint'($signed(res_score2)), s2);
            end
`endif
        end
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string name);
        @(negedge clk);
        chk({name, "_rdreq"}, longint'(fifo_rdreq), 0);
        chk({name, "_valid"}, longint'(res_valid), 0);
        chk({name, "_class"}, longint'(res_class), 0);
        chk({name, "_score"}, longint'(res_score), 0);
        chk({name, "_err"}, longint'(res_err), 0);
`ifdef ARGMAX_TOP2_EN
        chk({name, "_class2"}, longint'(res_class2), 0);
        chk({name, "_score2"}, longint'(res_score2), 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #2;
        reset = 1'b0;

        // 1: basic argmax
        push_image('{5, -3, 9, 2}, '{0, 0, 0, 1});
        wait_res("s1", 2, 9, 0, 0, 5);

        // 2: ties keep lowest index; all negative; back to back
        push_image('{7, 7, -1, 7}, '{0, 0, 0, 1});
        push_image('{-8, -2, -5, -9}, '{0, 0, 0, 1});
        wait_res("s2_tie", 0, 7, 0, 1, 7);
        wait_res("s2_neg", 1, -2, 0, 2, -5);

        // 3: backpressure with next image queued
        res_ready = 1'b0;
        push_image('{1, 2, 3, 4}, '{0, 0, 0, 1});
        push_image('{-1, -1, -1, -1}, '{0, 0, 0, 1});
        wait_res("s3_a", 3, 4, 0, 2, 3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("s3_hold_valid", longint'(res_valid), 1);
            chk("s3_hold_class", longint'(res_class), 3);
            chk("s3_hold_rdreq", longint'(fifo_rdreq), 0);
        end
        @(posedge clk);
        #2;
        res_ready = 1'b1;
        @(posedge clk);
        #2;
        wait_res("s3_b", 0, -1, 0, 1, -1);

        // 4: empty gaps between words
        gap_mode = 1;
        push_image('{5, -3, 9, 2}, '{0, 0, 0, 1});
        wait_res("s4", 2, 9, 0, 0, 5);
        gap_mode = 0;

        // 5: misplaced last flag, then a clean image
        push_image('{5, -3, 9, 2}, '{0, 1, 0, 0});
        wait_res("s5_err", 2, 9, 1, 0, 5);
        push_image('{5, -3, 9, 2}, '{0, 0, 0, 1});
        wait_res("s5_ok", 2, 9, 0, 0, 5);

        // 6: reset after 2 of 4 words, then a full image
        fq.push_back({1'b0, 32'sd10});
        fq.push_back({1'b0, 32'sd20});
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        fq.delete();
        @(posedge clk);
        check_reset_outputs("s6_reset");
        @(posedge clk);
        #2;
        reset = 1'b0;
        push_image('{1, 3, 2, 0}, '{0, 0, 0, 1});
        wait_res("s6", 1, 3, 0, 2, 2);

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", longint'(expq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
